// File: rtl/ripemd160_pkg.sv
// Shared constants for the RIPEMD-160 left-line sequencer: FSM encoding,
// r/s step tables and round constants.
package ripemd160_pkg;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t StIdle = 2'd0;
  localparam fsm_state_t StRun  = 2'd1;
  localparam fsm_state_t StDone = 2'd2;

  // One nibble per step, step 0 in the most significant nibble.
  localparam logic [319:0] R_LEFT = {
    64'h0123456789ABCDEF, 64'h74D1A6F3C0952EB8, 64'h3AE49F812706DB5C,
    64'h19BA08C4D37FE562, 64'h40597C2AE138B6FD
  };

  localparam logic [319:0] S_LEFT = {
    64'hBEFC5879BDEF6798, 64'h768DB97F7CF9B7DC, 64'hBD67E9DFE8D65C75,
    64'hBCEFEF989E56865C, 64'h9F5B68DC5CDEB856
  };

  localparam logic [31:0] K_LEFT0 = 32'h0000_0000;
  localparam logic [31:0] K_LEFT1 = 32'h5A82_7999;
  localparam logic [31:0] K_LEFT2 = 32'h6ED9_EBA1;
  localparam logic [31:0] K_LEFT3 = 32'h8F1B_BCDC;
  localparam logic [31:0] K_LEFT4 = 32'hA953_FD4E;

  function automatic logic [8:0] nib_top(input logic [6:0] j);
    return 9'd319 - {j, 2'b00};
  endfunction

  function automatic logic [3:0] left_r(input logic [6:0] j);
    return R_LEFT[nib_top(j) -: 4];
  endfunction

  function automatic logic [3:0] left_s(input logic [6:0] j);
    return S_LEFT[nib_top(j) -: 4];
  endfunction

  function automatic logic [31:0] left_k(input logic [2:0] t);
    case (t)
      3'd0:    return K_LEFT0;
      3'd1:    return K_LEFT1;
      3'd2:    return K_LEFT2;
      3'd3:    return K_LEFT3;
      3'd4:    return K_LEFT4;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/ripemd160_left_rom.sv
// Combinational step lookup: j -> message index r, rotate s, constant K, function select t.
module ripemd160_left_rom
  import ripemd160_pkg::*;
(
  input  logic [6:0]  j,
  output logic [3:0]  r,
  output logic [7:0]  s,
  output logic [31:0] k,
  output logic [2:0]  t
);

  always_comb begin
    r = '0;
    s = '0;
    k = '0;
    t = '0;
    if (j < 7'd80) begin
      r = left_r(j);
      s = {4'd0, left_s(j)};
      t = j[6:4];
      k = left_k(j[6:4]);
    end
  end

endmodule

// File: rtl/ripemd160_left_seq.sv
// RIPEMD-160 left-line sequencer: latches a block, drives 80 steps through an
// external step datapath and presents the final left-line state.
module ripemd160_left_seq
  import ripemd160_pkg::*;
#(
  parameter int unsigned STEPS = 80
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic [159:0] chain_i,
  output logic [159:0] step_state_o,
  output logic [31:0]  step_m_o,
  output logic [7:0]   step_s_o,
  output logic [31:0]  step_k_o,
  output logic [2:0]   step_t_o,
  input  logic [159:0] step_result_i,
  output logic         done_valid_o,
  input  logic         done_ready_i,
  output logic [159:0] left_state_o
);

  fsm_state_t   fsm_q, fsm_d;
  logic [6:0]   j_q, j_d;
  logic [159:0] state_q, state_d;
  logic [31:0]  x_q [16];
  logic         load_x;
  logic         run;
  logic         last;

  logic [3:0]   rom_r;
  logic [7:0]   rom_s;
  logic [31:0]  rom_k;
  logic [2:0]   rom_t;

  assign run  = (fsm_q == StRun);
  assign last = (j_q == 7'(STEPS - 1));

  ripemd160_left_rom u_rom (
    .j (j_q),
    .r (rom_r),
    .s (rom_s),
    .k (rom_k),
    .t (rom_t)
  );

  always_comb begin
    fsm_d   = fsm_q;
    j_d     = j_q;
    state_d = state_q;
    load_x  = 1'b0;
    case (fsm_q)
      StIdle: begin
        if (blk_valid_i) begin
          fsm_d   = StRun;
          j_d     = '0;
          state_d = chain_i;
          load_x  = 1'b1;
        end
      end
      StRun: begin
        state_d = step_result_i;
        if (last) fsm_d = StDone;
        else      j_d   = j_q + 7'd1;
      end
      StDone: begin
        if (done_ready_i) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      j_q     <= '0;
      state_q <= '0;
      for (int i = 0; i < 16; i++) x_q[i] <= '0;
    end else begin
      fsm_q   <= fsm_d;
      j_q     <= j_d;
      state_q <= state_d;
      if (load_x) begin
        for (int i = 0; i < 16; i++) x_q[i] <= blk_data_i[32*i +: 32];
      end
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign blk_ready_o  = (fsm_q == StIdle) && rst_n;
  assign done_valid_o = (fsm_q == StDone);
  assign left_state_o = done_valid_o ? state_q : '0;

  assign step_state_o = run ? state_q     : '0;
  assign step_m_o     = run ? x_q[rom_r]  : '0;
  assign step_s_o     = run ? rom_s       : '0;
  assign step_k_o     = run ? rom_k       : '0;
  assign step_t_o     = run ? rom_t       : '0;

endmodule

// File: tb/tb_ripemd160_left_seq.sv
// Scoreboard bench for ripemd160_left_seq with a behavioural step datapath.
module tb_ripemd160_left_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid_i = 1'b0;
  logic         blk_ready_o;
  logic [511:0] blk_data_i = '0;
  logic [159:0] chain_i = '0;
  logic [159:0] step_state_o;
  logic [31:0]  step_m_o;
  logic [7:0]   step_s_o;
  logic [31:0]  step_k_o;
  logic [2:0]   step_t_o;
  logic [159:0] step_result_i;
  logic         done_valid_o;
  logic         done_ready_i = 1'b0;
  logic [159:0] left_state_o;

  bit ident_mode = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  int r_tab [80] = '{
     0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15,
     7,  4, 13,  1, 10,  6, 15,  3, 12,  0,  9,  5,  2, 14, 11,  8,
     3, 10, 14,  4,  9, 15,  8,  1,  2,  7,  0,  6, 13, 11,  5, 12,
     1,  9, 11, 10,  0,  8, 12,  4, 13,  3,  7, 15, 14,  5,  6,  2,
     4,  0,  5,  9,  7, 12,  2, 10, 14,  1,  3,  8, 11,  6, 15, 13};
  int s_tab [80] = '{
    11, 14, 15, 12,  5,  8,  7,  9, 11, 13, 14, 15,  6,  7,  9,  8,
     7,  6,  8, 13, 11,  9,  7, 15,  7, 12, 15,  9, 11,  7, 13, 12,
    11, 13,  6,  7, 14,  9, 13, 15, 14,  8, 13,  6,  5, 12,  7,  5,
    11, 12, 14, 15, 14, 15,  9,  8,  9, 14,  5,  6,  8,  6,  5, 12,
     9, 15,  5, 11,  6,  8, 13, 12,  5, 12, 13, 14, 11,  8,  5,  6};

  typedef struct {
    logic [31:0]  m;
    logic [159:0] st;
  } exp_t;

  exp_t         sb [$];
  logic [159:0] fin_q [$];

  ripemd160_left_seq #(.STEPS(80)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .blk_valid_i   (blk_valid_i),
    .blk_ready_o   (blk_ready_o),
    .blk_data_i    (blk_data_i),
    .chain_i       (chain_i),
    .step_state_o  (step_state_o),
    .step_m_o      (step_m_o),
    .step_s_o      (step_s_o),
    .step_k_o      (step_k_o),
    .step_t_o      (step_t_o),
    .step_result_i (step_result_i),
    .done_valid_o  (done_valid_o),
    .done_ready_i  (done_ready_i),
    .left_state_o  (left_state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] k_of(input int rnd);
    case (rnd)
      0:       return 32'h00000000;
      1:       return 32'h5A827999;
      2:       return 32'h6ED9EBA1;
      3:       return 32'h8F1BBCDC;
      default: return 32'hA953FD4E;
    endcase
  endfunction

  // Non-trivial datapath stand-in so a state register that fails to load is visible.
  function automatic logic [159:0] step_f(input logic [159:0] st, input logic [31:0] m,
                                          input logic [7:0] s, input logic [31:0] k,
                                          input logic [2:0] t);
    return {st[127:0], st[159:128] + m + k + {24'd0, s} + {29'd0, t}};
  endfunction

  always_comb begin
    step_result_i = ident_mode ? step_state_o
                               : step_f(step_state_o, step_m_o, step_s_o, step_k_o, step_t_o);
  end

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag, input bit ready_exp);
    check_eq({tag, "_state"}, step_state_o, '0);
    check_eq({tag, "_m"}, {128'd0, step_m_o}, '0);
    check_eq({tag, "_skt"}, {117'd0, step_s_o, step_k_o, step_t_o}, '0);
    check_eq({tag, "_done"}, {159'd0, done_valid_o}, '0);
    check_eq({tag, "_left"}, left_state_o, '0);
    check_eq({tag, "_ready"}, {159'd0, blk_ready_o}, {159'd0, ready_exp});
  endtask

  task automatic run_block(input logic [511:0] x, input logic [159:0] ch, input bit ident,
                           input int hold, input int inject_at, input int reset_at);
    logic [159:0] st;
    logic [159:0] fin;
    logic [31:0]  m;
    exp_t         e;
    int           seen;
    ident_mode = ident;
    st = ch;
    for (int j = 0; j < 80; j++) begin
      m    = x[32*r_tab[j] +: 32];
      e.m  = m;
      e.st = st;
      sb.push_back(e);
      if (!ident) st = step_f(st, m, 8'(s_tab[j]), k_of(j / 16), 3'(j / 16));
    end
    fin_q.push_back(st);

    @(negedge clk);
    check_eq("ready_idle", {159'd0, blk_ready_o}, 160'd1);
    blk_valid_i = 1'b1;
    blk_data_i  = x;
    chain_i     = ch;
    @(negedge clk);
    blk_valid_i = 1'b0;
    blk_data_i  = ~x;
    chain_i     = ~ch;
    for (int j = 0; j < 80; j++) begin
      if (j > 0) @(negedge clk);
      e = sb.pop_front();
      check_eq($sformatf("m_j%0d", j), {128'd0, step_m_o}, {128'd0, e.m});
      check_eq($sformatf("state_j%0d", j), step_state_o, e.st);
      check_eq($sformatf("skt_j%0d", j), {117'd0, step_s_o, step_k_o, step_t_o},
               {117'd0, 8'(s_tab[j]), k_of(j / 16), 3'(j / 16)});
      check_eq($sformatf("ctl_j%0d", j), {157'd0, blk_ready_o, done_valid_o, |left_state_o},
               '0);
      if (j == 0)
        check_eq("j0_fixed", {117'd0, step_m_o, step_s_o, step_k_o, step_t_o},
                 {117'd0, x[31:0], 8'd11, 32'h0, 3'd0});
      if (j == 16)
        check_eq("j16_fixed", {117'd0, step_m_o, step_s_o, step_k_o, step_t_o},
                 {117'd0, x[7*32 +: 32], 8'd7, 32'h5A827999, 3'd1});
      if (j == 79)
        check_eq("j79_fixed", {117'd0, step_m_o, step_s_o, step_k_o, step_t_o},
                 {117'd0, x[13*32 +: 32], 8'd6, 32'hA953FD4E, 3'd4});
      blk_valid_i = (j == inject_at);
      if (j == inject_at) blk_data_i = x ^ {16{32'hDEADBEEF}};
      if (j == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid", 1'b0);
        sb.delete();
        fin_q.delete();
        blk_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("rst_rel", 1'b1);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (done_valid_o) seen++;
        end
        check_eq("no_done_after_rst", 160'(seen), '0);
        return;
      end
    end

    @(negedge clk);
    blk_valid_i = 1'b0;
    fin = fin_q.pop_front();
    check_eq("done_at_81", {159'd0, done_valid_o}, 160'd1);
    check_eq("left_state", left_state_o, fin);
    check_eq("done_step_zero", {85'd0, step_m_o, step_s_o, step_k_o, step_t_o, |step_state_o},
             '0);
    check_eq("done_ready_low", {159'd0, blk_ready_o}, '0);
    done_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq($sformatf("hold%0d_left", h), left_state_o, fin);
      check_eq($sformatf("hold%0d_ctl", h), {158'd0, done_valid_o, blk_ready_o}, 160'd2);
    end
    // Offer a block in the exit cycle; it must not be taken.
    done_ready_i = 1'b1;
    blk_valid_i  = 1'b1;
    blk_data_i   = ~x;
    @(negedge clk);
    done_ready_i = 1'b0;
    check_eq("exit_idle", {158'd0, done_valid_o, blk_ready_o}, 160'd1);
    check_eq("exit_step_zero", {117'd0, step_m_o, step_s_o, step_k_o, step_t_o}, '0);
    blk_valid_i = 1'b0;
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [511:0] x0;
    logic [159:0] ch;
    for (int i = 0; i < 16; i++) x0[32*i +: 32] = 32'h0101_0101 * (i + 1) ^ 32'hA5000000;
    repeat (3) @(negedge clk);
    check_all_zero("in_rst", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_rst", 1'b1);

    run_block(x0, IV, 1'b1, 10, -1, -1);
    ch = {$urandom, $urandom, $urandom, $urandom, $urandom};
    run_block(rand_blk(), ch, 1'b0, 2, 20, -1);
    run_block(rand_blk(), IV, 1'b1, 0, -1, 40);
    ch = {$urandom, $urandom, $urandom, $urandom, $urandom};
    run_block(rand_blk(), ch, 1'b0, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
